// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Shares one memory port between an instruction-fetch port (if_*) and a
// data port (dm_*). One transaction is in flight at a time. A grant in IDLE
// registers the request onto mem_* and the FSM waits in BUSY_IF / BUSY_DM
// for mem_ready. Completion produces a one-cycle ack on the granted port in
// the following cycle. A transaction that sees no mem_ready for TIMEOUT
// BUSY cycles is aborted with ack + err and zero read data.
//
// Arbitration:
//   default                     : data port wins simultaneous requests.
//   MEM_ARB_ROUND_ROBIN_EN      : simultaneous requests go to the port that
//                                 was not granted last (last grant resets
//                                 to IF, so DM wins the first tie).
//
// Handshake: a requester raises x_req and holds it, with its address/data
// stable, until it sees x_ack high at a rising edge. x_ack is a one-cycle
// pulse and x_rdata is valid in that cycle and held until the port's next
// completion. On the memory side, mem_req and all mem_* outputs stay
// constant from the grant until the cycle after mem_ready (or timeout).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request and byte address
//   if_rdata/if_ack          fetch data and completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be           data-port request, store flag, address, data,
//                            byte enables
//   dm_rdata/dm_ack          load data and completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be         shared memory request
//   mem_rdata/mem_ready      memory read data and completion strobe
//   err                      pulses with the ack of a timed-out transaction
//   stall_if/stall_mem       pipeline stall requests
//   dbg_state                current FSM state (0 IDLE, 1 BUSY_IF, 2 BUSY_DM)
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_DM = 2'd2
  } state_t;

  // The abort fires on the BUSY cycle whose count equals TIMEOUT-1, so the
  // transaction has spent exactly TIMEOUT cycles in BUSY when it is dropped.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        elig_if, elig_dm;
  logic        grant_if, grant_dm;

  // A port whose ack is high this cycle is still holding a request that has
  // already been served; masking it prevents a duplicate grant and lets the
  // other port take the slot back-to-back.
  assign elig_if = if_req & ~if_ack_q;
  assign elig_dm = dm_req & ~dm_ack_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  logic last_grant_q, last_grant_d;

  assign grant_dm = elig_dm & (~elig_if | (last_grant_q == GRANT_IF));
`else
  assign grant_dm = elig_dm;
`endif
  assign grant_if = elig_if & ~grant_dm;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      S_IDLE: begin
        // mem_ready is deliberately not looked at here.
        if (grant_dm) begin
          state_d     = S_BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
          cnt_d       = 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = GRANT_DM;
`endif
        end else if (grant_if) begin
          state_d     = S_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'hF;
          cnt_d       = 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = GRANT_IF;
`endif
        end
      end

      S_BUSY_IF, S_BUSY_DM: begin
        if (mem_ready || (cnt_q == CNT_LAST)) begin
          // Normal completion takes precedence over a timeout on the same
          // cycle; err marks the abort case only.
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = 8'd0;
          err_d     = ~mem_ready;
          if (state_q == S_BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : 32'd0;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_ready) begin
              dm_rdata_d = 32'd0;
            end else if (!mem_we_q) begin
              // Stores leave the previous load data visible.
              dm_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        cnt_d     = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= GRANT_IF;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed bench for memory_arbiter (TIMEOUT = 4). A memory responder
// returns data a fixed number of cycles after mem_req rises; every
// completion expected by a directed step is pushed to exp_q and a monitor
// pops and compares it when if_ack or dm_ack pulses. Cycle-exact checks of
// the memory-side request and stall outputs run alongside the requesters.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err;
  logic        stall_if;
  logic        stall_mem;
  logic [1:0]  dbg_state;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .err(err), .stall_if(stall_if),
    .stall_mem(stall_mem), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];          // {is_dm, err, rdata}
  logic [31:0] model_dm_rdata;
  logic [33:0] mon_obs, mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic push_if(input logic e, input logic [31:0] d);
    exp_q.push_back({1'b0, e, d});
  endtask

  task automatic push_dm_load(input logic [31:0] a);
    model_dm_rdata = mem_fn(a);
    exp_q.push_back({1'b1, 1'b0, model_dm_rdata});
  endtask

  task automatic push_dm_store();
    exp_q.push_back({1'b1, 1'b0, model_dm_rdata});
  endtask

  always @(negedge clk) begin
    if (if_ack === 1'b1 || dm_ack === 1'b1) begin
      mon_obs = {dm_ack, err, (dm_ack ? dm_rdata : if_rdata)};
      if (if_ack && dm_ack) check("ack_onehot", 64'(if_ack & dm_ack), 64'(0));
      if (exp_q.size() == 0) begin
        check("ack_with_empty_queue", 64'(exp_q.size()), 64'(1));
      end else begin
        mon_exp = exp_q.pop_front();
        check("ack_result", 64'(mon_obs), 64'(mon_exp));
      end
    end
    if (rst === 1'b0) begin
      if (err && !if_ack && !dm_ack) check("err_without_ack", 64'(err), 64'(0));
      check("stall_if_eq", 64'(stall_if), 64'(if_req & ~if_ack));
      check("stall_mem_eq", 64'(stall_mem), 64'(dm_req & ~dm_ack));
    end
  end

  // ---------------- memory responder ----------------
  int mem_lat = 1;                 // 0 = never ready
  logic force_ready = 1'b0;
  int busy_cnt = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1) busy_cnt++;
      else busy_cnt = 0;
      if (mem_req === 1'b1 && mem_lat > 0 && busy_cnt == mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_fn(mem_addr);
      end else begin
        mem_ready = force_ready;
        mem_rdata = force_ready ? 32'hBAD0BAD0 : 32'd0;
      end
    end
  end

  // ---------------- driver tasks (call at posedge + 1) ----------------
  task automatic fetch_req(input logic [31:0] a);
    bit got = 0;
    if_addr = a;
    if_req  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_ack === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) check("fetch_ack_wait", 64'(if_ack), 64'(1));
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    bit got = 0;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = d;
    dm_be    = be;
    dm_req   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dm_ack === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) check("dm_ack_wait", 64'(dm_ack), 64'(1));
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    dm_we  = 1'b0;
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rr_addr[4];
  logic [31:0] first_addr;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_be = 4'd0;
    model_dm_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ctrl", 64'({mem_req, mem_we, if_ack, dm_ack, err, dbg_state}), 64'(0));
    check("rst_mem_bus", 64'({mem_addr, mem_wdata}), 64'(0));
    check("rst_mem_be", 64'(mem_be), 64'(0));
    check("rst_rdata", 64'({if_rdata, dm_rdata}), 64'(0));

    // Fetch only, minimum latency
    mem_lat = 1;
    push_if(1'b0, 32'hDEADBEEF);
    start_cycle();
    fork
      fetch_req(32'h100);
      begin
        @(negedge clk);
        check("f1_c0_memreq", 64'(mem_req), 64'(0));
        check("f1_c0_stall", 64'(stall_if), 64'(1));
        @(negedge clk);
        check("f1_c1_req_addr", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h100}));
        check("f1_c1_we_be", 64'({mem_we, mem_be}), 64'({1'b0, 4'hF}));
        check("f1_c1_state", 64'(dbg_state), 64'(1));
        @(negedge clk);
        check("f1_c2_ack", 64'({if_ack, mem_req, stall_if}), 64'({1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        check("f1_c3_no_regrant", 64'({mem_req, dbg_state}), 64'(0));
      end
    join
    repeat (2) @(negedge clk);

    // Simultaneous fetch and load, latency 2: dm first, if back-to-back
    mem_lat = 2;
    push_dm_load(32'h40);
    push_if(1'b0, mem_fn(32'h0));
    start_cycle();
    fork
      fetch_req(32'h0);
      dm_access(1'b0, 32'h40, 32'd0, 4'hF);
      begin
        @(negedge clk);
        check("s2_c0_stalls", 64'({stall_if, stall_mem}), 64'(2'b11));
        @(negedge clk);
        check("s2_c1_dm_grant", 64'({mem_req, dbg_state, mem_addr}), 64'({1'b1, 2'd2, 32'h40}));
        check("s2_c1_stall_if", 64'(stall_if), 64'(1));
        @(negedge clk);
        check("s2_c2_stall_if", 64'(stall_if), 64'(1));
        @(negedge clk);
        check("s2_c3_dm_ack", 64'({dm_ack, stall_if, stall_mem}), 64'(3'b110));
        @(negedge clk);
        check("s2_c4_if_grant", 64'({mem_req, dbg_state, mem_addr}), 64'({1'b1, 2'd1, 32'h0}));
      end
    join
    repeat (2) @(negedge clk);

    // Continuous requests from both ports: DM, IF, DM, IF
    mem_lat = 1;
    rr_addr[0] = 32'h2000; rr_addr[1] = 32'h1000;
    rr_addr[2] = 32'h2004; rr_addr[3] = 32'h1004;
    push_dm_load(32'h2000);
    push_if(1'b0, mem_fn(32'h1000));
    push_dm_load(32'h2004);
    push_if(1'b0, mem_fn(32'h1004));
    start_cycle();
    fork
      begin fetch_req(32'h1000); fetch_req(32'h1004); end
      begin dm_access(1'b0, 32'h2000, 32'd0, 4'hF); dm_access(1'b0, 32'h2004, 32'd0, 4'hF); end
      begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("alt_grant_addr", 64'({mem_req, mem_addr}), 64'({1'b1, rr_addr[k]}));
          @(negedge clk);
        end
      end
    join
    repeat (2) @(negedge clk);

    // Lone load (last grant = DM), then a tie decided by the arbitration mode
    push_dm_load(32'h48);
    start_cycle();
    dm_access(1'b0, 32'h48, 32'd0, 4'hF);
    repeat (2) @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_addr = 32'h50;
    push_if(1'b0, mem_fn(32'h50));
    push_dm_load(32'h58);
`else
    first_addr = 32'h58;
    push_dm_load(32'h58);
    push_if(1'b0, mem_fn(32'h50));
`endif
    start_cycle();
    fork
      fetch_req(32'h50);
      dm_access(1'b0, 32'h58, 32'd0, 4'hF);
      begin
        @(negedge clk);
        @(negedge clk);
        check("tie_first_grant", 64'(mem_addr), 64'(first_addr));
      end
    join
    repeat (2) @(negedge clk);

    // Store: mem side carries we/be/data, dm_rdata keeps last load value
    mem_lat = 2;
    push_dm_store();
    start_cycle();
    fork
      dm_access(1'b1, 32'h80, 32'h12345678, 4'b0011);
      begin
        @(negedge clk);
        @(negedge clk);
        check("st_c1_bus", 64'({mem_req, mem_we, mem_be, mem_addr}), 64'({1'b1, 1'b1, 4'b0011, 32'h80}));
        check("st_c1_wdata", 64'(mem_wdata), 64'(32'h12345678));
        @(negedge clk);
        check("st_c2_stable", 64'({mem_req, mem_we, mem_be, mem_addr}), 64'({1'b1, 1'b1, 4'b0011, 32'h80}));
        @(negedge clk);
        check("st_c3_ack", 64'({dm_ack, mem_req}), 64'(2'b10));
      end
    join
    repeat (2) @(negedge clk);

    // Timeout: no mem_ready for TIMEOUT busy cycles
    mem_lat = 0;
    push_if(1'b1, 32'd0);
    start_cycle();
    fork
      fetch_req(32'h200);
      begin
        repeat (5) @(negedge clk);
        check("to_c4_busy", 64'({mem_req, dbg_state, if_ack}), 64'({1'b1, 2'd1, 1'b0}));
        @(negedge clk);
        check("to_c5_abort", 64'({if_ack, err, mem_req, dbg_state}), 64'({1'b1, 1'b1, 1'b0, 2'd0}));
        @(negedge clk);
        check("to_c6_idle", 64'({mem_req, err}), 64'(0));
      end
    join
    repeat (2) @(negedge clk);

    // Ready on the last allowed busy cycle completes normally
    mem_lat = 4;
    push_if(1'b0, mem_fn(32'h204));
    start_cycle();
    fork
      fetch_req(32'h204);
      begin
        repeat (6) @(negedge clk);
        check("to_edge_ack", 64'({if_ack, err}), 64'(2'b10));
      end
    join
    repeat (2) @(negedge clk);

    // mem_ready while idle is ignored
    force_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_ready_ignored", 64'({dbg_state, mem_req, if_ack, dm_ack, err}), 64'(0));
    end
    force_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during BUSY_DM: no ack, back to reset values, then a clean load
    mem_lat = 0;
    start_cycle();
    dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hF; dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rb_c1_busy_dm", 64'({mem_req, dbg_state}), 64'({1'b1, 2'd2}));
    start_cycle();
    rst = 1'b1;
    dm_req = 1'b0;
    start_cycle();
    rst = 1'b0;
    model_dm_rdata = 32'd0;
    @(negedge clk);
    check("rb_after_rst", 64'({mem_req, dm_ack, err, dbg_state}), 64'(0));
    check("rb_after_rst_bus", 64'({mem_addr, dm_rdata}), 64'(0));
    @(negedge clk);
    check("rb_no_late_ack", 64'({dm_ack, mem_req}), 64'(0));
    mem_lat = 1;
    push_dm_load(32'h44);
    start_cycle();
    dm_access(1'b0, 32'h44, 32'd0, 4'hF);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
